// File: rtl/muldiv_seq_if.sv
// Request/result and shared-ALU signals for the multi-cycle multiply/divide sequencer.
// The master side is the EX-stage environment; the slave side is the sequencer.
interface muldiv_seq_if;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        ex_alu_req;
    logic        alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_carry;

    modport master (
        output start, op, src_a, src_b, ex_alu_req, alu_out, alu_carry,
        input  busy, done, hi, lo, div_by_zero, alu_sel, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  start, op, src_a, src_b, ex_alu_req, alu_out, alu_carry,
        output busy, done, hi, lo, div_by_zero, alu_sel, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/muldiv_seq.sv
// Unsigned 32x32 multiply / 32/32 divide, one shift-add or restoring-subtract step per cycle,
// borrowing the EX-stage ALU only in cycles EX leaves free.
module muldiv_seq #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_seq_if.slave   bus
);
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [31:0] hi_q, hi_d;      // P_hi for multiply, remainder R for divide
    logic [31:0] lo_q, lo_d;      // P_lo for multiply, quotient Q for divide
    logic [31:0] opnd_q, opnd_d;  // multiplicand M or divisor D
    logic        dbz_q, dbz_d;
    logic        needs_alu;
    logic        step_go;
    logic [31:0] r_shift;

    always_comb begin
        r_shift   = {hi_q[30:0], lo_q[31]};
        needs_alu = op_q || lo_q[0] || !ZERO_SKIP;
        step_go   = (state_q == RUN) && !(needs_alu && bus.ex_alu_req);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opnd_q  <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            dbz_q   <= dbz_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = (bus.op && bus.src_b == 32'd0) ? DONE : RUN;
            RUN:  if (step_go && cnt_q == 5'd31) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        dbz_d  = dbz_q;
        if (state_q == IDLE && bus.start) begin
            op_d  = bus.op;
            cnt_d = 5'd0;
            if (bus.op && bus.src_b == 32'd0) begin
                hi_d  = bus.src_a;
                lo_d  = 32'hFFFF_FFFF;
                dbz_d = 1'b1;
            end else begin
                hi_d   = 32'd0;
                lo_d   = bus.op ? bus.src_a : bus.src_b;
                opnd_d = bus.op ? bus.src_b : bus.src_a;
                dbz_d  = 1'b0;
            end
        end else if (step_go) begin
            cnt_d = cnt_q + 5'd1;
            if (op_q) begin
                // A set top bit of R means R' exceeds 32 bits and always covers D.
                if (hi_q[31] || bus.alu_carry) begin
                    hi_d = bus.alu_out;
                    lo_d = {lo_q[30:0], 1'b1};
                end else begin
                    hi_d = r_shift;
                    lo_d = {lo_q[30:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                hi_d = {bus.alu_carry, bus.alu_out[31:1]};
                lo_d = {bus.alu_out[0], lo_q[31:1]};
            end else begin
                hi_d = {1'b0, hi_q[31:1]};
                lo_d = {hi_q[0], lo_q[31:1]};
            end
        end
    end

    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.done        = (state_q == DONE);
        bus.hi          = hi_q;
        bus.lo          = lo_q;
        bus.div_by_zero = dbz_q;
        bus.alu_sel     = (state_q == RUN) && needs_alu && !bus.ex_alu_req;
        bus.alu_a       = 32'd0;
        bus.alu_b       = 32'd0;
        bus.alu_ctrl    = ALU_ADD;
        if (bus.alu_sel) begin
            bus.alu_a    = op_q ? r_shift : hi_q;
            bus.alu_b    = opnd_q;
            bus.alu_ctrl = op_q ? ALU_SUB : ALU_ADD;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Vector-table bench for muldiv_seq: two instances (zero-skip on/off) share stimulus,
// a behavioural ALU, and per-instance scoreboards checked on each done pulse.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        ex_req = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          start_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          ex_lo;
        int          ex_hi;
        int          poke;
        int          lat0;
        int          lat1;
    } vec_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    muldiv_seq_if b0 ();
    muldiv_seq_if b1 ();

    muldiv_seq #(.ZERO_SKIP(1'b1)) dut0 (.clk(clk), .resetn(resetn), .bus(b0.slave));
    muldiv_seq #(.ZERO_SKIP(1'b0)) dut1 (.clk(clk), .resetn(resetn), .bus(b1.slave));

    assign b0.start = start;  assign b1.start = start;
    assign b0.op = op;        assign b1.op = op;
    assign b0.src_a = src_a;  assign b1.src_a = src_a;
    assign b0.src_b = src_b;  assign b1.src_b = src_b;
    assign b0.ex_alu_req = ex_req;
    assign b1.ex_alu_req = ex_req;

    // Shared ALU: ADD = A+B, SUB = A+~B+1, carry out of bit 31.
    assign {b0.alu_carry, b0.alu_out} = (b0.alu_ctrl == 2'b11)
        ? ({1'b0, b0.alu_a} + {1'b0, ~b0.alu_b} + 33'd1) : ({1'b0, b0.alu_a} + {1'b0, b0.alu_b});
    assign {b1.alu_carry, b1.alu_out} = (b1.alu_ctrl == 2'b11)
        ? ({1'b0, b1.alu_a} + {1'b0, ~b1.alu_b} + 33'd1) : ({1'b0, b1.alu_a} + {1'b0, b1.alu_b});

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic on_done(input int which, input logic [31:0] hi, input logic [31:0] lo,
                           input logic dbz, input logic busy);
        exp_t e;
        if ((which == 0 && exp_q0.size() == 0) || (which == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL spurious_done: dut%0d pulsed done with nothing pending (cycle %0d)", which, cyc);
        end else begin
            e = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("hi_dut%0d", which), 64'(hi), 64'(e.hi));
            check($sformatf("lo_dut%0d", which), 64'(lo), 64'(e.lo));
            check($sformatf("dbz_dut%0d", which), 64'(dbz), 64'(e.dbz));
            check($sformatf("latency_dut%0d", which), 64'(cyc - e.start_cyc), 64'(e.lat));
            check($sformatf("busy_at_done_dut%0d", which), 64'(busy), 64'd1);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && b0.done) on_done(0, b0.hi, b0.lo, b0.div_by_zero, b0.busy);
        if (resetn && b1.done) on_done(1, b1.hi, b1.lo, b1.div_by_zero, b1.busy);
    end

    function automatic vec_t mk(logic o, logic [31:0] a, logic [31:0] b, logic [31:0] hi,
                                logic [31:0] lo, logic dbz, int ex_lo, int ex_hi, int poke,
                                int lat0, int lat1);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz;
        v.ex_lo = ex_lo; v.ex_hi = ex_hi; v.poke = poke; v.lat0 = lat0; v.lat1 = lat1;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   t0;
        int   guard;
        exp_t e;
        @(posedge clk); #1;
        op = v.op; src_a = v.a; src_b = v.b; start = 1'b1; ex_req = 1'b0;
        t0 = cyc;
        e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz; e.start_cyc = t0;
        e.lat = v.lat0; exp_q0.push_back(e);
        e.lat = v.lat1; exp_q1.push_back(e);
        @(negedge clk);
        check("busy_cycle0", 64'({b0.busy, b1.busy}), 64'd0);
        guard = 0;
        while ((exp_q0.size() > 0 || exp_q1.size() > 0) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            start  = (cyc - t0 == v.poke);
            if (start) begin
                op = 1'b1; src_a = 32'd9; src_b = 32'd3;
            end
            ex_req = (cyc - t0 >= v.ex_lo) && (cyc - t0 <= v.ex_hi);
            @(negedge clk); #1;
            if (ex_req) check("alu_sel_while_ex", 64'({b0.alu_sel, b1.alu_sel}), 64'd0);
            if (!b0.alu_sel) check("alu_idle_dut0", {30'd0, b0.alu_a, b0.alu_ctrl}, {30'd0, 32'd0, 2'b10});
            if (!b0.alu_sel) check("alu_idle_b_dut0", 64'(b0.alu_b), 64'd0);
        end
        ex_req = 1'b0;
        start  = 1'b0;
        if (guard >= 300) begin
            checks++;
            failures++;
            $display("FAIL timeout: no done within %0d cycles (cycle %0d)", guard, cyc);
            exp_q0.delete();
            exp_q1.delete();
        end
    endtask

    vec_t vecs[11];

    initial begin
        logic [63:0] prod;
        int          t0;
        prod = 64'(32'hDEAD_BEEF) * 64'(32'h1234_5678);
        vecs[0]  = mk(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1, 0, -1, 33, 33);
        vecs[1]  = mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1, 0, -1, 33, 33);
        vecs[2]  = mk(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, 0, -1, 33, 33);
        vecs[3]  = mk(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 1'b0, 1, 0, -1, 33, 33);
        vecs[4]  = mk(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, 0, -1, 1, 1);
        vecs[5]  = mk(1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1, 0, -1, 33, 33);
        vecs[6]  = mk(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 4, 8, -1, 38, 38);
        vecs[7]  = mk(1'b0, 32'd3, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 1, 31, -1, 33, 64);
        vecs[8]  = mk(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, prod[63:32], prod[31:0], 1'b0, 1, 0, -1, 33, 33);
        vecs[9]  = mk(1'b1, 32'hDEAD_BEEF, 32'h1234, 32'hDEAD_BEEF % 32'h1234, 32'hDEAD_BEEF / 32'h1234,
                      1'b0, 1, 0, -1, 33, 33);
        vecs[10] = mk(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1, 0, 10, 33, 33);

        #3;
        check("rst_flags", 64'({b0.busy, b0.done, b0.div_by_zero, b0.alu_sel}), 64'd0);
        check("rst_hilo", {b0.hi, b0.lo}, 64'd0);
        check("rst_alu", {30'd0, b0.alu_a, b0.alu_ctrl}, {30'd0, 32'd0, 2'b10});
        check("rst_alu_b", 64'(b0.alu_b), 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Abort a multiply with reset in cycle 15.
        @(posedge clk); #1;
        op = 1'b0; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
        t0 = cyc;
        while (cyc - t0 < 15) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("abort_running", 64'(b0.busy), 64'd1);
        resetn = 1'b0;
        #1;
        check("abort_flags", 64'({b0.busy, b0.done, b0.div_by_zero, b0.alu_sel, b1.busy, b1.done}), 64'd0);
        check("abort_hilo", {b0.hi, b0.lo}, 64'd0);
        check("abort_alu", {30'd0, b0.alu_a, b0.alu_ctrl}, {30'd0, 32'd0, 2'b10});
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle", 64'({b0.busy, b0.done, b1.busy, b1.done}), 64'd0);
        end

        run_vec(vecs[2]);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
